// File: rtl/dsp_simd_addsub.sv
// dsp_simd_addsub: LANES-wide SIMD add/sub/accumulate/load on signed WIDTH-bit lanes.
// Two-stage pipeline: S1 captures operands, S2 registers result, overflow flags and
// the per-lane accumulators. A single global advance stalls both stages together.
// Optional feature: define DSP_SIMD_ADDSUB_SAT_EN to saturate overflowing lanes
// instead of wrapping them.
module dsp_simd_addsub #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned LANES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [LANES*WIDTH-1:0]   a,
    input  logic [LANES*WIDTH-1:0]   b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   y,
    output logic [LANES-1:0]         ovf
);

    localparam int unsigned DW = LANES * WIDTH;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    // Reject out-of-range configurations at elaboration time.
    if (WIDTH < 1 || WIDTH > 12) begin : g_bad_width
        $error("dsp_simd_addsub: WIDTH must be in 1..12");
    end
    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $error("dsp_simd_addsub: LANES must be in 1..4");
    end

`ifdef DSP_SIMD_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic [WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

    // Pipeline state
    logic            s1_valid;
    logic [1:0]      s1_op;
    logic [DW-1:0]   s1_a;
    logic [DW-1:0]   s1_b;
    logic [DW-1:0]   acc;

    // Combinational lane results computed from S1 and the accumulators
    logic [DW-1:0]   res_c;
    logic [LANES-1:0] ovf_c;
    logic            advance_c;
    logic            acc_wr_c;

    // Whole pipeline moves when the output slot is empty or being consumed.
    assign advance_c = !out_valid || out_ready;
    assign in_ready  = reset && advance_c;

    // Only accumulate and load beats write back into the accumulators.
    assign acc_wr_c = (s1_op == OP_ACC) || (s1_op == OP_LOAD);

    // Per-lane arithmetic, one extra bit of headroom to detect signed overflow.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] lane_a;
        logic [WIDTH-1:0] lane_b;
        logic [WIDTH-1:0] lane_acc;
        logic [WIDTH:0]   ext_a;
        logic [WIDTH:0]   ext_b;
        logic [WIDTH:0]   ext_acc;
        logic [WIDTH:0]   sum;
        logic             lane_ovf;
        logic [WIDTH-1:0] lane_res;

        assign lane_a   = s1_a[i*WIDTH +: WIDTH];
        assign lane_b   = s1_b[i*WIDTH +: WIDTH];
        assign lane_acc = acc[i*WIDTH +: WIDTH];

        assign ext_a   = {lane_a[WIDTH-1], lane_a};
        assign ext_b   = {lane_b[WIDTH-1], lane_b};
        assign ext_acc = {lane_acc[WIDTH-1], lane_acc};

        // Select the exact (WIDTH+1)-bit signed result for this lane.
        always_comb begin
            sum = ext_a;
            case (s1_op)
                OP_ADD:  sum = ext_a + ext_b;
                OP_SUB:  sum = ext_a - ext_b;
                OP_ACC:  sum = ext_acc + ext_a;
                default: sum = ext_a;
            endcase
        end

        // Overflow when the two top bits disagree; a load can never overflow.
        assign lane_ovf = (s1_op != OP_LOAD) && (sum[WIDTH] != sum[WIDTH-1]);

`ifdef DSP_SIMD_ADDSUB_SAT_EN
        // Clamp toward the sign of the exact result.
        assign lane_res = lane_ovf ? (sum[WIDTH] ? SAT_MIN : SAT_MAX) : sum[WIDTH-1:0];
`else
        // Two's complement wrap: keep the low WIDTH bits.
        assign lane_res = sum[WIDTH-1:0];
`endif

        assign res_c[i*WIDTH +: WIDTH] = lane_res;
        assign ovf_c[i]                = lane_ovf;
    end

    // S1: operand register; a bubble enters when no beat is offered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_op    <= 2'b00;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (advance_c) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op;
                s1_a  <= a;
                s1_b  <= b;
            end
        end
    end

    // S2: result register and accumulator write-back; y/ovf hold across bubbles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= '0;
            acc       <= '0;
        end else if (advance_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y   <= res_c;
                ovf <= ovf_c;
                if (acc_wr_c) begin
                    acc <= res_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp_simd_addsub.sv
// Self-checking bench for dsp_simd_addsub (WIDTH=12, LANES=3): directed scenarios
// followed by randomized traffic, all checked against an integer reference model.
module tb_dsp_simd_addsub;

    localparam int unsigned W  = 12;
    localparam int unsigned L  = 3;
    localparam int unsigned DW = W * L;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] y;
    logic [L-1:0]  ovf;

    dsp_simd_addsub #(.WIDTH(W), .LANES(L)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] y;
        logic [L-1:0]  ovf;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t sb[$];
    int   macc[L];
    int   cyc      = 0;
    int   n_total  = 0;
    int   n_pass   = 0;
    int   n_out    = 0;
    bit   lat_mode = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] pack(input int l0, input int l1, input int l2);
        return {12'(l2), 12'(l1), 12'(l0)};
    endfunction

    // Reference: exact integer arithmetic, then clamp or wrap into a lane.
    function automatic exp_t model_beat(input logic [1:0] o, input logic [DW-1:0] va,
                                        input logic [DW-1:0] vb);
        exp_t e;
        e.y   = '0;
        e.ovf = '0;
        e.cyc = 0;
        e.lat = 1'b0;
        for (int i = 0; i < L; i++) begin
            logic signed [W-1:0] sa;
            logic signed [W-1:0] sbv;
            logic signed [W-1:0] wr;
            int x;
            int z;
            int r;
            sa  = va[i*W +: W];
            sbv = vb[i*W +: W];
            x   = sa;
            z   = sbv;
            case (o)
                2'd0:    r = x + z;
                2'd1:    r = x - z;
                2'd2:    r = macc[i] + x;
                default: r = x;
            endcase
            e.ovf[i] = (o != 2'd3) && (r > MAXV || r < MINV);
`ifdef DSP_SIMD_ADDSUB_SAT_EN
            if (r > MAXV) r = MAXV;
            if (r < MINV) r = MINV;
`endif
            wr = W'(r);
            e.y[i*W +: W] = wr;
            if (o >= 2'd2) macc[i] = wr;
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] rnd_operand();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < L; i++) begin
            case ($urandom_range(0, 4))
                0:       v[i*W +: W] = 12'h7ff;
                1:       v[i*W +: W] = 12'h800;
                2:       v[i*W +: W] = 12'h000;
                3:       v[i*W +: W] = 12'hfff;
                default: v[i*W +: W] = 12'($urandom);
            endcase
        end
        return v;
    endfunction

    // Scoreboard: record accepted beats and compare every consumed result.
    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset) begin
            sb.delete();
            for (int i = 0; i < L; i++) macc[i] = 0;
        end else begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("beat_y", 64'(y), 64'(e.y));
                    check("beat_ovf", 64'(ovf), 64'(e.ovf));
                    if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(2));
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                e     = model_beat(op, a, b);
                e.cyc = cyc;
                e.lat = lat_mode;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic [DW-1:0] va, input logic [DW-1:0] vb);
        int k;
        in_valid = 1'b1;
        op = o;
        a  = va;
        b  = vb;
        for (k = 0; k < 50; k++) begin
            @(negedge clock);
            if (in_ready) break;
        end
        check("accept_timeout", 64'(k < 50), 64'(1));
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (k = 0; k < 20 && sb.size() != 0; k++) @(posedge clock);
        @(posedge clock);
        #1;
        check("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    // Single beat into an empty pipeline; result must appear on the second edge.
    task automatic send_expect(input string tag, input logic [1:0] o, input logic [DW-1:0] va,
                               input logic [DW-1:0] vb, input logic [DW-1:0] ey,
                               input logic [L-1:0] eo);
        send(o, va, vb);
        @(negedge clock);
        check({tag, "_early"}, 64'(out_valid), 64'(0));
        @(negedge clock);
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_y"}, 64'(y), 64'(ey));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n0;
        logic [DW-1:0] sa5;
        logic [DW-1:0] sb5;
        reset = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_y", 64'(y), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        lat_mode = 1'b1;
        @(negedge clock);
        check("idle_in_ready", 64'(in_ready), 64'(1));
        @(posedge clock);
        #1;

        // Add and sub with boundary operands
        send_expect("add", 2'b00, pack(5, -3, 100), pack(7, -4, -100), pack(12, -7, 0), 3'b000);
`ifdef DSP_SIMD_ADDSUB_SAT_EN
        send_expect("sub", 2'b01, pack(2047, 0, -2048), pack(-1, 1, 1), pack(2047, -1, -2048), 3'b101);
`else
        send_expect("sub", 2'b01, pack(2047, 0, -2048), pack(-1, 1, 1), pack(-2048, -1, 2047), 3'b101);
`endif

        // Load then back-to-back accumulates
        send(2'b11, pack(10, 20, 30), pack(99, 99, 99));
        repeat (3) send(2'b10, pack(1, 2, 3), pack(5, 5, 5));
        drain();
        send_expect("acc_chain", 2'b10, pack(0, 0, 0), '0, pack(13, 26, 39), 3'b000);

        // Accumulator overflow
        send(2'b11, pack(0, 0, 0), '0);
        send(2'b10, pack(2047, 2047, 2047), '0);
        drain();
`ifdef DSP_SIMD_ADDSUB_SAT_EN
        send_expect("acc_ovf", 2'b10, pack(2047, 2047, 2047), '0, pack(2047, 2047, 2047), 3'b111);
`else
        send_expect("acc_ovf", 2'b10, pack(2047, 2047, 2047), '0, pack(-2, -2, -2), 3'b111);
`endif

        // Eight-beat stream with a three-cycle downstream stall
        lat_mode = 1'b0;
        n0 = n_out;
        for (int k = 0; k < 4; k++) send(2'b00, rnd_operand(), rnd_operand());
        sa5 = rnd_operand();
        sb5 = rnd_operand();
        in_valid = 1'b1; op = 2'b00; a = sa5; b = sb5;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        send(2'b00, sa5, sb5);
        for (int k = 0; k < 3; k++) send(2'b00, rnd_operand(), rnd_operand());
        drain();
        check("stream_count", 64'(n_out - n0), 64'(8));

        // Reset with two beats in flight
        lat_mode = 1'b1;
        send(2'b11, pack(50, 50, 50), '0);
        drain();
        lat_mode = 1'b0;
        out_ready = 1'b0;
        send(2'b10, pack(1, 1, 1), '0);
        send(2'b10, pack(1, 1, 1), '0);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_y", 64'(y), 64'(0));
        @(posedge clock);
        #1;
        lat_mode = 1'b1;
        send_expect("post_rst_acc", 2'b10, pack(1, 1, 1), '0, pack(1, 1, 1), 3'b000);

        // Randomized traffic with random backpressure
        lat_mode = 1'b0;
        repeat (400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 2'($urandom_range(0, 3));
            a         = rnd_operand();
            b         = rnd_operand();
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
